// File: rtl/ctrl_seq_master_if.sv
// AXI-Lite bundle between the control sequencer (master) and the controlled
// block's register slave.
interface ctrl_seq_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ctrl_seq_master.sv
// Bring-up sequencer: config-table writes, then CONNECT and CLOSE write/poll over AXI-Lite.
// Define CTRL_SEQ_TIMEOUT_EN to bound each poll phase to POLL_MAX reads (err_code 3).
//
// state   | meaning
// IDLE    | out of reset, waiting for start
// WR      | AW and W valid, each dropped on its own ready
// WR_RESP | bready high, waiting for bvalid
// RD      | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// DONE    | sequence complete, finish high
// ERR     | sequence aborted, err and err_code valid
module ctrl_seq_master #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          NUM_CFG    = 5,
  parameter int          CONN_ADDR  = 5,
  parameter int          CLOSE_ADDR = 6,
  parameter logic [31:0] CONN_DONE  = 32'h10,
  parameter logic [31:0] CLOSE_DONE = 32'h1000,
  parameter int          POLL_MAX   = 1024
) (
  input  logic                      core_clk,
  input  logic                      core_rst,
  input  logic                      start,
  input  logic [NUM_CFG*ADDR_W-1:0] cfg_addr,
  input  logic [NUM_CFG*DATA_W-1:0] cfg_data,
  ctrl_seq_master_if.master         ctrl_s_axi,
  output logic                      busy,
  output logic                      finish,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int IDX_W  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] EC_WRESP   = 2'd1;
  localparam logic [1:0] EC_RRESP   = 2'd2;
  localparam logic [1:0] EC_TIMEOUT = 2'd3;

  if (NUM_CFG < 1 || NUM_CFG > 16) begin : g_bad_num_cfg
    $error("ctrl_seq_master: NUM_CFG must be 1..16");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("ctrl_seq_master: DATA_W must be 32 or 64");
  end
  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("ctrl_seq_master: POLL_MAX must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, DONE, ERR} state_t;
  typedef enum logic [1:0] {PH_CFG, PH_CONN, PH_CLOSE} phase_t;

  state_t              state, state_d;
  phase_t              phase, phase_d;
  logic [IDX_W-1:0]    idx, idx_d, idx_inc;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                finish_q, finish_d, err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                do_wr, do_rd, aw_left, w_left;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data, done_val;

  logic [ADDR_W-1:0]   tbl_addr [NUM_CFG];
  logic [DATA_W-1:0]   tbl_data [NUM_CFG];

`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam int PC_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  logic [PC_W-1:0]     poll_cnt, poll_cnt_d;
`endif

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_tbl
    assign tbl_addr[i] = cfg_addr[i*ADDR_W +: ADDR_W];
    assign tbl_data[i] = cfg_data[i*DATA_W +: DATA_W];
  end

  assign idx_inc  = idx + IDX_W'(1);
  assign done_val = (phase == PH_CONN) ? DATA_W'(CONN_DONE) : DATA_W'(CLOSE_DONE);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= IDLE;
      phase      <= PH_CFG;
      idx        <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      araddr_q   <= '0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
`ifdef CTRL_SEQ_TIMEOUT_EN
      poll_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      idx        <= idx_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      araddr_q   <= araddr_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef CTRL_SEQ_TIMEOUT_EN
      poll_cnt   <= poll_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    idx_d      = idx;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    araddr_d   = araddr_q;
    finish_d   = finish_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    do_wr      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    do_rd      = 1'b0;
    rd_addr    = '0;
    aw_left    = awvalid_q && !ctrl_s_axi.awready;
    w_left     = wvalid_q && !ctrl_s_axi.wready;
`ifdef CTRL_SEQ_TIMEOUT_EN
    poll_cnt_d = poll_cnt;
`endif

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          finish_d   = 1'b0;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          phase_d    = PH_CFG;
          idx_d      = '0;
          do_wr      = 1'b1;
          wr_addr    = tbl_addr[0];
          wr_data    = tbl_data[0];
`ifdef CTRL_SEQ_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      WR: begin
        // AW and W retire independently; the response is only awaited once both are gone
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (ctrl_s_axi.bvalid) begin
          bready_d = 1'b0;
          if (ctrl_s_axi.bresp != 2'b00) begin
            state_d    = ERR;
            err_d      = 1'b1;
            err_code_d = EC_WRESP;
          end else begin
            case (phase)
              PH_CFG: begin
                if (idx == IDX_W'(NUM_CFG - 1)) begin
                  phase_d = PH_CONN;
                  do_wr   = 1'b1;
                  wr_addr = ADDR_W'(CONN_ADDR);
                end else begin
                  idx_d   = idx_inc;
                  do_wr   = 1'b1;
                  wr_addr = tbl_addr[idx_inc];
                  wr_data = tbl_data[idx_inc];
                end
              end
              PH_CONN: begin
                do_rd   = 1'b1;
                rd_addr = ADDR_W'(CONN_ADDR);
              end
              default: begin
                do_rd   = 1'b1;
                rd_addr = ADDR_W'(CLOSE_ADDR);
              end
            endcase
          end
        end
      end
      RD: begin
        if (ctrl_s_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (ctrl_s_axi.rvalid) begin
          rready_d = 1'b0;
          if (ctrl_s_axi.rresp != 2'b00) begin
            state_d    = ERR;
            err_d      = 1'b1;
            err_code_d = EC_RRESP;
          end else if (ctrl_s_axi.rdata == done_val) begin
`ifdef CTRL_SEQ_TIMEOUT_EN
            poll_cnt_d = '0;
`endif
            if (phase == PH_CONN) begin
              phase_d = PH_CLOSE;
              do_wr   = 1'b1;
              wr_addr = ADDR_W'(CLOSE_ADDR);
            end else begin
              state_d  = DONE;
              finish_d = 1'b1;
            end
          end
`ifdef CTRL_SEQ_TIMEOUT_EN
          else if (poll_cnt == PC_W'(POLL_MAX - 1)) begin
            state_d    = ERR;
            err_d      = 1'b1;
            err_code_d = EC_TIMEOUT;
          end
`endif
          else begin
`ifdef CTRL_SEQ_TIMEOUT_EN
            poll_cnt_d = poll_cnt + PC_W'(1);
`endif
            do_rd   = 1'b1;
            rd_addr = araddr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // launching from the handshake cycle keeps the gap to the next valid at zero
    if (do_wr) begin
      state_d   = WR;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = wr_addr;
      wdata_d   = wr_data;
      wstrb_d   = '1;
    end
    if (do_rd) begin
      state_d   = RD;
      arvalid_d = 1'b1;
      araddr_d  = rd_addr;
    end
  end

  assign ctrl_s_axi.awvalid = awvalid_q;
  assign ctrl_s_axi.awaddr  = awaddr_q;
  assign ctrl_s_axi.wvalid  = wvalid_q;
  assign ctrl_s_axi.wdata   = wdata_q;
  assign ctrl_s_axi.wstrb   = wstrb_q;
  assign ctrl_s_axi.bready  = bready_q;
  assign ctrl_s_axi.arvalid = arvalid_q;
  assign ctrl_s_axi.araddr  = araddr_q;
  assign ctrl_s_axi.rready  = rready_q;

  assign busy     = !(state inside {IDLE, DONE, ERR});
  assign finish   = finish_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_ctrl_seq_master.sv
// Directed bench for ctrl_seq_master: scripted AXI-Lite slave plus transaction scoreboard.
module tb_ctrl_seq_master;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NUM_CFG  = 5;
  localparam int POLL_MAX = 8;

  logic                      core_clk = 1'b0;
  logic                      core_rst;
  logic                      start;
  logic [NUM_CFG*ADDR_W-1:0] cfg_addr;
  logic [NUM_CFG*DATA_W-1:0] cfg_data;
  logic                      busy, finish, err;
  logic [1:0]                err_code;

  ctrl_seq_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  ctrl_seq_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CFG(NUM_CFG), .POLL_MAX(POLL_MAX)
  ) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .start     (start),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .ctrl_s_axi(axi),
    .busy      (busy),
    .finish    (finish),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // slave knobs (written by the stimulus block only)
  int aw_delay, w_delay, err_wr_num, conn_match, close_match;

  // slave state (written by the slave process only)
  int                aw_cnt, w_cnt, wr_num, conn_rd, close_rd;
  bit                aw_fire, w_fire, ar_fire, b_fire, r_fire, have_aw, have_w;
  bit                aw_hold, w_hold;
  logic [ADDR_W-1:0] log_awaddr, log_araddr, hold_awaddr;
  logic [DATA_W-1:0] log_wdata, hold_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic sb_pop(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    total++;
    assert (exp_q.size() != 0) else begin
      bad++;
      $error("FAIL sb_unexpected observed=is_wr:%0d addr:0x%0h expected=no transaction", is_wr, a);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_kind", 64'(is_wr), 64'(e.is_wr));
      check("sb_addr", 64'(a), 64'(e.addr));
      if (is_wr) check("sb_data", 64'(d), 64'(e.data));
    end
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.is_wr = 1'b1;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.is_wr = 1'b0;
    e.addr  = a;
    e.data  = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg(input int n);
    for (int i = 0; i < n; i++) push_wr(cfg_addr[i*ADDR_W +: ADDR_W], cfg_data[i*DATA_W +: DATA_W]);
  endtask

  task automatic push_seq(input int n_conn, input int n_close);
    push_cfg(NUM_CFG);
    push_wr(32'd5, 32'd0);
    for (int i = 0; i < n_conn; i++) push_rd(32'd5);
    push_wr(32'd6, 32'd0);
    for (int i = 0; i < n_close; i++) push_rd(32'd6);
  endtask

  task automatic pulse_start();
    @(posedge core_clk);
    #1 start = 1'b1;
    @(posedge core_clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge core_clk);
      if (finish || err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_busy"},     64'(busy),        64'd0);
    check({pre, "_finish"},   64'(finish),      64'd0);
    check({pre, "_err"},      64'(err),         64'd0);
    check({pre, "_err_code"}, 64'(err_code),    64'd0);
    check({pre, "_awvalid"},  64'(axi.awvalid), 64'd0);
    check({pre, "_awaddr"},   64'(axi.awaddr),  64'd0);
    check({pre, "_wvalid"},   64'(axi.wvalid),  64'd0);
    check({pre, "_wdata"},    64'(axi.wdata),   64'd0);
    check({pre, "_wstrb"},    64'(axi.wstrb),   64'd0);
    check({pre, "_bready"},   64'(axi.bready),  64'd0);
    check({pre, "_arvalid"},  64'(axi.arvalid), 64'd0);
    check({pre, "_araddr"},   64'(axi.araddr),  64'd0);
    check({pre, "_rready"},   64'(axi.rready),  64'd0);
  endtask

  // scripted slave: decides readies for the next rising edge on each falling edge
  always @(negedge core_clk) begin
    if (core_rst) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata  = '0;   axi.rresp = 2'b00;
      aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
      have_aw = 0; have_w = 0; aw_hold = 0; w_hold = 0;
      aw_cnt = 0; w_cnt = 0; wr_num = 0; conn_rd = 0; close_rd = 0;
    end else begin
      if (start) begin
        wr_num = 0; conn_rd = 0; close_rd = 0;
      end
      if (b_fire) axi.bvalid = 1'b0;
      if (r_fire) axi.rvalid = 1'b0;
      if (aw_fire) have_aw = 1'b1;
      if (w_fire) have_w = 1'b1;
      if (have_aw && have_w && !axi.bvalid) begin
        wr_num++;
        axi.bvalid = 1'b1;
        axi.bresp  = (wr_num == err_wr_num) ? 2'b10 : 2'b00;
        have_aw = 1'b0;
        have_w  = 1'b0;
        sb_pop(1'b1, log_awaddr, log_wdata);
      end
      if (ar_fire) begin
        axi.rvalid = 1'b1;
        axi.rresp  = 2'b00;
        if (log_araddr == 32'd5) begin
          conn_rd++;
          axi.rdata = (conn_rd == conn_match) ? 32'h10 : 32'h1000;
        end else begin
          close_rd++;
          axi.rdata = (close_rd == close_match) ? 32'h1000 : 32'h10;
        end
        sb_pop(1'b0, log_araddr, '0);
      end
      if (aw_hold) begin
        check("aw_held", 64'(axi.awvalid), 64'd1);
        check("awaddr_stable", 64'(axi.awaddr), 64'(hold_awaddr));
      end
      if (w_hold) begin
        check("w_held", 64'(axi.wvalid), 64'd1);
        check("wdata_stable", 64'(axi.wdata), 64'(hold_wdata));
      end

      axi.awready = axi.awvalid && !have_aw && (aw_cnt >= aw_delay);
      aw_cnt      = (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      aw_fire     = axi.awvalid && axi.awready;
      aw_hold     = axi.awvalid && !axi.awready;
      hold_awaddr = axi.awaddr;
      if (aw_fire) log_awaddr = axi.awaddr;

      axi.wready  = axi.wvalid && !have_w && (w_cnt >= w_delay);
      w_cnt       = (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      w_fire      = axi.wvalid && axi.wready;
      w_hold      = axi.wvalid && !axi.wready;
      hold_wdata  = axi.wdata;
      if (w_fire) begin
        log_wdata = axi.wdata;
        check("wstrb_ones", 64'(axi.wstrb), 64'hf);
      end

      axi.arready = axi.arvalid;
      ar_fire     = axi.arvalid;
      if (ar_fire) log_araddr = axi.araddr;
      b_fire = axi.bvalid && axi.bready;
      r_fire = axi.rvalid && axi.rready;

      if (axi.awvalid || axi.wvalid || axi.bready || axi.arvalid || axi.rready)
        check("one_outstanding",
              64'((axi.awvalid || axi.wvalid || axi.bready) && (axi.arvalid || axi.rready)), 64'd0);
      check("finish_err_excl", 64'(finish && err), 64'd0);
    end
  end

  initial begin
    bit ok;
    bit found;
    bit any_valid;
    core_rst    = 1'b0;
    start       = 1'b0;
    aw_delay    = 0;
    w_delay     = 0;
    err_wr_num  = 0;
    conn_match  = 3;
    close_match = 1;
    for (int i = 0; i < NUM_CFG; i++) begin
      cfg_addr[i*ADDR_W +: ADDR_W] = 32'h100 + 32'(i * 4);
      cfg_data[i*DATA_W +: DATA_W] = $urandom;
    end

    #1 core_rst = 1'b1;
    #2 check_zero("reset");
    repeat (3) @(posedge core_clk);
    #1 core_rst = 1'b0;
    repeat (10) @(negedge core_clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_awvalid", 64'(axi.awvalid), 64'd0);
    check("idle_finish", 64'(finish), 64'd0);

    // full sequence, zero-wait slave
    push_seq(3, 1);
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    check("start_awvalid", 64'(axi.awvalid), 64'd1);
    wait_end(ok);
    check("basic_end", 64'(ok), 64'd1);
    check("basic_finish", 64'(finish), 64'd1);
    check("basic_err", 64'(err), 64'd0);
    check("basic_busy", 64'(busy), 64'd0);
    check("basic_sb_left", 64'(exp_q.size()), 64'd0);

    // restart from DONE, W ready 4 cycles ahead of AW, stray start mid-config
    aw_delay = 4;
    push_seq(3, 1);
    pulse_start();
    check("restart_finish_clr", 64'(finish), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    repeat (3) @(posedge core_clk);
    pulse_start();
    check("ignored_start_busy", 64'(busy), 64'd1);
    wait_end(ok);
    check("skew_end", 64'(ok), 64'd1);
    check("skew_finish", 64'(finish), 64'd1);
    check("skew_err", 64'(err), 64'd0);
    check("skew_sb_left", 64'(exp_q.size()), 64'd0);
    aw_delay = 0;

    // write response error on the 2nd config write
    err_wr_num = 2;
    push_cfg(2);
    pulse_start();
    wait_end(ok);
    check("wresp_end", 64'(ok), 64'd1);
    check("wresp_err", 64'(err), 64'd1);
    check("wresp_code", 64'(err_code), 64'd1);
    check("wresp_finish", 64'(finish), 64'd0);
    check("wresp_busy", 64'(busy), 64'd0);
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge core_clk);
      any_valid |= axi.awvalid | axi.wvalid | axi.bready | axi.arvalid | axi.rready;
    end
    check("wresp_quiet", 64'(any_valid), 64'd0);
    check("wresp_sb_left", 64'(exp_q.size()), 64'd0);
    err_wr_num = 0;

`ifdef CTRL_SEQ_TIMEOUT_EN
    // CONNECT never matches: exactly POLL_MAX reads, then timeout
    conn_match = 0;
    push_cfg(NUM_CFG);
    push_wr(32'd5, 32'd0);
    for (int i = 0; i < POLL_MAX; i++) push_rd(32'd5);
    pulse_start();
    check("tmo_err_clr", 64'(err), 64'd0);
    wait_end(ok);
    repeat (3) @(negedge core_clk);
    check("tmo_end", 64'(ok), 64'd1);
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_code", 64'(err_code), 64'd3);
    check("tmo_sb_left", 64'(exp_q.size()), 64'd0);
`else
    // without the timeout, polling carries on past POLL_MAX reads
    conn_match = 12;
    push_seq(12, 1);
    pulse_start();
    check("poll_err_clr", 64'(err), 64'd0);
    wait_end(ok);
    check("poll_end", 64'(ok), 64'd1);
    check("poll_finish", 64'(finish), 64'd1);
    check("poll_err", 64'(err), 64'd0);
    check("poll_sb_left", 64'(exp_q.size()), 64'd0);
`endif

    // reset while arvalid is high, then a clean full run
    conn_match = 0;
    push_cfg(NUM_CFG);
    push_wr(32'd5, 32'd0);
    push_rd(32'd5);
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge core_clk);
      if (axi.arvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_arvalid_seen", 64'(found), 64'd1);
    #2 core_rst = 1'b1;
    #1 check_zero("midrst");
    check("midrst_sb_left", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge core_clk);
    #1 core_rst = 1'b0;
    repeat (5) @(negedge core_clk);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_arvalid", 64'(axi.arvalid), 64'd0);
    conn_match = 3;
    push_seq(3, 1);
    pulse_start();
    wait_end(ok);
    check("postrst_end", 64'(ok), 64'd1);
    check("postrst_finish", 64'(finish), 64'd1);
    check("postrst_err", 64'(err), 64'd0);
    check("postrst_sb_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
